// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path and its line filters.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    ACK,
    WAIT_IDLE,
    ABORT
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_START_TO  = 2'b01;
  localparam logic [1:0] ERR_PACKET_TO = 2'b10;
  localparam logic [1:0] ERR_NO_ACK    = 2'b11;

  localparam int DEF_INHIBIT_CYCLES = 6000;
  localparam int DEF_START_TIMEOUT  = 750000;
  localparam int DEF_PACKET_TIMEOUT = 100000;
  localparam int DEF_FILTER_CYCLES  = 8;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: 2-flop synchroniser, stability filter and a registered falling-edge pulse.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic line_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          filt_q, filt_d;
  logic          filt_dly_q;
  logic          fall_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The filtered value only follows the synchronised line after it has
  // disagreed for FILTER_CYCLES consecutive cycles; any agreement restarts.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) filt_d = sync2_q;
      else                   cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      filt_q     <= 1'b1;
      filt_dly_q <= 1'b1;
      fall_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= line_i;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      fall_q     <= filt_dly_q & ~filt_q;
      cnt_q      <= cnt_d;
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts one
// command byte out on device clock falls and checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int PACKET_TIMEOUT = DEF_PACKET_TIMEOUT,
  parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output ps2_state_e state_dbg
);

  localparam int INH_W   = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int START_W = (START_TIMEOUT  > 1) ? $clog2(START_TIMEOUT)  : 1;
  localparam int PKT_W   = (PACKET_TIMEOUT > 1) ? $clog2(PACKET_TIMEOUT) : 1;

  localparam logic [INH_W-1:0]   INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [INH_W-1:0]   INH_HALF   = INH_W'(INHIBIT_CYCLES / 2);
  localparam logic [START_W-1:0] START_LAST = START_W'(START_TIMEOUT - 1);
  localparam logic [PKT_W-1:0]   PKT_LAST   = PKT_W'(PACKET_TIMEOUT - 1);

  ps2_state_e         state_q, state_d;
  logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [START_W-1:0] start_cnt_q, start_cnt_d;
  logic [PKT_W-1:0]   pkt_cnt_q, pkt_cnt_d, pkt_next;
  logic [3:0]         bit_idx_q, bit_idx_d;
  logic [8:0]         frame_q, frame_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ready_en_q;
  logic               pkt_expired;

  logic clk_filt, clk_fall;
  logic dat_filt, dat_fall_unused;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
    .clk    (clk),
    .resetn (resetn),
    .line_i (ps2_clk_in),
    .filt_o (clk_filt),
    .fall_o (clk_fall)
  );

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_dat_filter (
    .clk    (clk),
    .resetn (resetn),
    .line_i (ps2_dat_in),
    .filt_o (dat_filt),
    .fall_o (dat_fall_unused)
  );

  assign pkt_expired = (pkt_cnt_q == PKT_LAST);
  assign pkt_next    = pkt_expired ? pkt_cnt_q : pkt_cnt_q + 1'b1;

  // frame_q holds {parity, data}; bit_idx_q selects the bit currently driven.
  // Counters default to zero so each one restarts whenever its state is entered.
  always_comb begin
    state_d     = state_q;
    inh_cnt_d   = '0;
    start_cnt_d = '0;
    pkt_cnt_d   = '0;
    bit_idx_d   = bit_idx_q;
    frame_d     = frame_q;
    err_code_d  = err_code_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          frame_d    = {odd_parity(tx_data), tx_data};
          err_code_d = ERR_NONE;
          state_d    = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == INH_LAST) state_d   = REQ;
        else                       inh_cnt_d = inh_cnt_q + 1'b1;
      end
      REQ: begin
        if (start_cnt_q == START_LAST) begin
          state_d    = ABORT;
          err_code_d = ERR_START_TO;
        end else if (clk_fall) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end else begin
          start_cnt_d = start_cnt_q + 1'b1;
        end
      end
      DATA: begin
        pkt_cnt_d = pkt_next;
        if (pkt_expired) begin
          state_d    = ABORT;
          err_code_d = ERR_PACKET_TO;
        end else if (clk_fall) begin
          if (bit_idx_q == 4'd8) state_d   = ACK;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      ACK: begin
        pkt_cnt_d = pkt_next;
        if (pkt_expired) begin
          state_d    = ABORT;
          err_code_d = ERR_PACKET_TO;
        end else if (clk_fall) begin
          if (!dat_filt) begin
            state_d = WAIT_IDLE;
          end else begin
            state_d    = ABORT;
            err_code_d = ERR_NO_ACK;
          end
        end
      end
      WAIT_IDLE: begin
        pkt_cnt_d = pkt_next;
        if (pkt_expired) begin
          state_d    = ABORT;
          err_code_d = ERR_PACKET_TO;
        end else if (clk_filt && dat_filt) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      ABORT: begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      inh_cnt_q   <= '0;
      start_cnt_q <= '0;
      pkt_cnt_q   <= '0;
      bit_idx_q   <= '0;
      frame_q     <= '0;
      err_code_q  <= ERR_NONE;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      inh_cnt_q   <= inh_cnt_d;
      start_cnt_q <= start_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      bit_idx_q   <= bit_idx_d;
      frame_q     <= frame_d;
      err_code_q  <= err_code_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ready_en_q  <= 1'b1;
    end
  end

  // Line enables decode straight from state so an async reset frees the bus at once.
  always_comb begin
    ps2_dat_oe = 1'b0;
    unique case (state_q)
      INHIBIT: ps2_dat_oe = (inh_cnt_q >= INH_HALF);
      REQ:     ps2_dat_oe = 1'b1;
      DATA:    ps2_dat_oe = ~frame_q[bit_idx_q];
      default: ps2_dat_oe = 1'b0;
    endcase
  end

  assign ps2_clk_oe = (state_q == INHIBIT);
  assign tx_ready   = (state_q == IDLE) && ready_en_q;
  assign rx_inhibit = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a bus-level PS/2 device model drives directed transfers
// from a vector table, plus hand sequences for reset, busy requests and glitches.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH       = 6000;
  localparam int START_TO  = 1000;
  localparam int PKT_TO    = 5000;
  localparam int FILT      = 8;
  localparam int HALF      = 40;
  localparam int START_DLY = 200;

  logic       clk = 1'b0;
  logic       resetn;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       rx_inhibit, done, err;
  logic [1:0] err_code;
  ps2_state_e state_dbg;
  logic       dev_clk_low, dev_dat_low;
  logic       ps2_clk_line, ps2_dat_line;

  assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

  always #10 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (START_TO),
    .PACKET_TIMEOUT (PKT_TO),
    .FILTER_CYCLES  (FILT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_line),
    .ps2_dat_in (ps2_dat_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .rx_inhibit (rx_inhibit),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .state_dbg  (state_dbg)
  );

  int checks = 0;
  int failures = 0;
  int done_tot = 0;
  int err_tot = 0;
  int viol_tot = 0;
  int rst_age = 0;

  // Running totals of pulses and of handshake-rule breaches seen on the outputs.
  always @(negedge clk) begin
    if (!resetn) rst_age <= 0;
    else         rst_age <= rst_age + 1;
    if (resetn && done) done_tot <= done_tot + 1;
    if (resetn && err)  err_tot  <= err_tot + 1;
    viol_tot <= viol_tot
              + int'(resetn && rst_age >= 3 && (tx_ready == rx_inhibit))
              + int'(resetn && (done || err) && !tx_ready);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    chk("ready_before_send", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side: measures the inhibit window, then clocks nfalls bits, sampling
  // data on each rising clock, optionally ACKing and glitching the clock once.
  task automatic dev_run(input int nfalls, input bit ack, input bit glitch,
                         output logic [9:0] frame, output int inh_len,
                         output int dat_mid, output int t_err);
    int n;
    frame   = '0;
    inh_len = 0;
    dat_mid = -1;
    t_err   = -1;
    n = 0;
    while (!ps2_clk_oe && n < 50) begin @(negedge clk); n++; end
    while (ps2_clk_oe && inh_len < 7000) begin
      if (ps2_dat_oe && dat_mid < 0) dat_mid = inh_len;
      inh_len++;
      @(negedge clk);
    end
    if (nfalls == 0) begin
      n = 0;
      while (!err && n < 3000) begin @(negedge clk); n++; end
      t_err = n;
    end else begin
      repeat (START_DLY) @(negedge clk);
      for (int k = 0; k < nfalls; k++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        if (k < 10) frame[k] = ps2_dat_line;
        if (k == 9 && ack) dev_dat_low = 1'b1;
        if (glitch && k == 3) begin
          repeat (10) @(negedge clk);
          dev_clk_low = 1'b1;
          repeat (3) @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (HALF - 13) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
        end
      end
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_end(input int d0, input int e0);
    int n = 0;
    while (!(tx_ready && (done_tot + err_tot > d0 + e0)) && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("end_in_time", n < 10000, 1);
    repeat (20) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    int         nfalls;
    bit         ack;
    bit         glitch;
    logic [1:0] exp_code;
    int         exp_done;
    int         exp_err;
    logic [9:0] exp_frame;
  } vec_t;

  vec_t       vecs[5];
  vec_t       v;
  logic [9:0] frame;
  int         inh_len, dat_mid, t_err, d0, e0, n;

  initial begin
    // frame = {stop, parity, data}; F4 has five ones (parity 0), ED six (parity 1).
    vecs[0] = '{8'hF4, 11, 1'b1, 1'b0, 2'b00, 1, 0, 10'h2F4};
    vecs[1] = '{8'hED, 11, 1'b1, 1'b1, 2'b00, 1, 0, 10'h3ED};
    vecs[2] = '{8'hFF,  0, 1'b0, 1'b0, 2'b01, 0, 1, 10'h000};
    vecs[3] = '{8'hED,  4, 1'b0, 1'b0, 2'b10, 0, 1, 10'h000};
    vecs[4] = '{8'hF4, 11, 1'b0, 1'b0, 2'b11, 0, 1, 10'h2F4};

    resetn      = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {tx_ready, ps2_clk_oe, ps2_dat_oe, rx_inhibit, done, err, err_code}, 8'h00);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", {tx_ready, ps2_clk_oe, ps2_dat_oe, rx_inhibit, done, err, err_code}, 8'h80);

    for (int i = 0; i < 5; i++) begin
      v  = vecs[i];
      d0 = done_tot;
      e0 = err_tot;
      fork
        dev_run(v.nfalls, v.ack, v.glitch, frame, inh_len, dat_mid, t_err);
        send(v.data);
      join
      wait_end(d0, e0);
      chk($sformatf("v%0d_inhibit_len", i), inh_len, INH);
      chk($sformatf("v%0d_dat_oe_start", i), dat_mid, INH / 2);
      if (v.nfalls >= 10) chk($sformatf("v%0d_frame", i), frame, v.exp_frame);
      if (v.nfalls == 0)  chk($sformatf("v%0d_start_to_time", i), (t_err >= START_TO && t_err <= START_TO + 2), 1);
      chk($sformatf("v%0d_done_count", i), done_tot - d0, v.exp_done);
      chk($sformatf("v%0d_err_count", i), err_tot - e0, v.exp_err);
      chk($sformatf("v%0d_err_code", i), err_code, v.exp_code);
      chk($sformatf("v%0d_released", i), {ps2_clk_oe, ps2_dat_oe, rx_inhibit, tx_ready}, 4'b0001);
    end

    // Second request while a byte is in flight must be dropped.
    d0 = done_tot;
    e0 = err_tot;
    fork
      dev_run(11, 1'b1, 1'b0, frame, inh_len, dat_mid, t_err);
      begin
        send(8'hED);
        n = 0;
        while (state_dbg != DATA && n < 10000) begin @(negedge clk); n++; end
        repeat (100) @(negedge clk);
        chk("busy_not_ready", tx_ready, 0);
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_end(d0, e0);
    repeat (200) @(negedge clk);
    chk("busy_frame", frame, 10'h3ED);
    chk("busy_done_count", done_tot - d0, 1);
    chk("busy_err_count", err_tot - e0, 0);
    chk("busy_err_code", err_code, 2'b00);
    chk("busy_no_requeue", {tx_ready, rx_inhibit}, 2'b10);

    // Asynchronous reset while driving a data bit.
    send(8'hF4);
    n = 0;
    while (ps2_clk_oe && n < 7000) begin @(negedge clk); n++; end
    repeat (50) @(negedge clk);
    dev_clk_low = 1'b1;
    n = 0;
    while (!(state_dbg == DATA && ps2_dat_oe) && n < 100) begin @(negedge clk); n++; end
    chk("pre_reset_dat_oe", ps2_dat_oe, 1);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1 chk("async_reset_release", {ps2_clk_oe, ps2_dat_oe, rx_inhibit, tx_ready}, 4'b0000);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", {tx_ready, rx_inhibit, err_code}, 4'b1000);

    chk("handshake_rules", viol_tot, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
